mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage load/store unit for the RV32I five-stage pipeline. It consumes the EX/MEM register contents (address, store data, funct3, control), runs a valid/ready transaction on the data-memory port, and formats load data for writeback. `StallMem` freezes the pipeline for the duration of the access.

## Interface
Parameters:
- none; XLEN is fixed at 32.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ValidM`  in  1  the MEM slot holds a real instruction (0 = bubble).
- `ALUResultM`  in  32  effective byte address.
- `WriteDataM`  in  32  store source register value.
- `funct3M`  in  3  access size and sign.
- `MemWriteM`  in  1  store.
- `ResultSrcM`  in  2  value 2'b01 = load.
- `dmem_valid`  out  1  request valid.
- `dmem_ready`  in  1  request accepted.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word address, `{ALUResultM[31:2],2'b00}`.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_strb`  out  4  byte enables.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read word.
- `ReadDataM`  out  32  extended load result, registered.
- `StallMem`  out  1  hold IF through MEM.
- `ExcM`  out  1  misaligned access or illegal funct3; combinational.

## Operation
- `access = ValidM & (MemWriteM | ResultSrcM==2'b01) & ~ExcM`.
- ExcM conditions:
  - halfword access with `addr[0]` set;
  - word access with `addr[1:0]` nonzero;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- On ExcM, the unit issues no request and raises no stall.
- Store strobes:
  - SB: `4'b0001 << addr[1:0]`, wdata = byte replicated ×4;
  - SH: `4'b0011 << {addr[1],1'b0}`, wdata = halfword replicated ×2;
  - SW: `4'b1111`, wdata unchanged.
- Loads drive `dmem_strb = 4'b1111`. The byte lane is selected by the captured `addr[1:0]`.
- Load extension:
  - 000 LB: sign-extend;
  - 001 LH: sign-extend;
  - 010 LW: no extension;
  - 100 LBU: zero-extend;
  - 101 LHU: zero-extend.
- FSM states: IDLE, REQ, RSP, DONE.
  - IDLE: `StallMem = access`. On `access`, capture addr, wdata, strb, we, funct3 and `addr[1:0]`, then go to REQ.
  - REQ: `dmem_valid=1`, outputs driven from the captured registers, `StallMem=1`. On `dmem_ready`, a store goes to DONE and a load goes to RSP.
  - RSP: `StallMem=1`. On `dmem_rvalid`, `ReadDataM` ← extended data, then go to DONE.
  - DONE: `StallMem=0`. The pipeline advances on this edge. Next state is IDLE.
- `ReadDataM` holds its value until the next load completes. Stores do not change it.

## Timing
- Reset values while `rst_n`=0:
  - state = IDLE;
  - `dmem_valid`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_strb` = 0;
  - `ReadDataM` = 0;
  - `StallMem` = 0 and `ExcM` = 0 (both gated by `rst_n`).
- Reset asserted mid-transaction: `dmem_valid` drops immediately (asynchronously), the FSM returns to IDLE and any pending response is discarded.
- Once `dmem_valid` is high, `dmem_addr`, `dmem_wdata`, `dmem_strb` and `dmem_we` stay stable until the cycle where `dmem_ready`=1. `dmem_valid` deasserts on the next cycle.
- `dmem_rvalid` is ignored outside RSP.
- `dmem_rvalid` in the same cycle as `dmem_ready` is not accepted: the response must arrive in RSP, one or more cycles later.
- Minimum latency:
  - store: 3 cycles (IDLE→REQ→DONE) with `dmem_ready` tied high;
  - load: 4 cycles with 1-cycle response.
- Back-to-back accesses re-enter IDLE for one cycle each. There is no overlapping of transactions.
- ValidM=0 or a non-memory instruction in IDLE: no state change, `StallMem`=0.

## Test plan
- SW, `addr=0x100`, `WriteDataM=0xDEADBEEF`, `dmem_ready` tied 1 → `dmem_valid` for 1 cycle with `addr=0x100`, `strb=1111`, `we=1`. `StallMem` high for 2 cycles, then low in DONE.
- SB, `addr=0x103`, `WriteDataM=0x000000A5` → `strb=1000`, `wdata=0xA5A5A5A5`. SH at `0x102`, data `0x1234` → `strb=1100`, `wdata=0x12341234`.
- LB at `0x101`, `rdata=0x0000_80_00` (byte1=0x80), `dmem_ready` delayed 3 cycles and `rvalid` 2 cycles after acceptance → `ReadDataM=0xFFFFFF80`, with `StallMem` covering the whole wait. LBU at the same address → `0x00000080`. LHU at `0x102` with `rdata=0xBEEF0000` → `0x0000BEEF`.
- LW at `0x102` → `ExcM=1`, `dmem_valid` never asserted, `StallMem=0`. Load with funct3=110 → `ExcM=1`.
- `rst_n` pulsed low during REQ → `dmem_valid` falls in the same cycle. After release the state is IDLE, a late `rvalid` is ignored and `ReadDataM=0`.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I memory-stage load/store unit with valid/ready data-memory port
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ValidM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  output logic        dmem_valid,
  input  logic        dmem_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_strb,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        ExcM
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  strb_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        is_store, is_load, misalign, illegal, exc, access;
  logic [31:0] fmt_wdata, load_ext, lane;
  logic [3:0]  fmt_strb;
  logic        stall;

  always_comb begin
    is_store = MemWriteM;
    is_load  = ~MemWriteM & (ResultSrcM == 2'b01);
    misalign = ((funct3M[1:0] == 2'b01) & ALUResultM[0]) |
               ((funct3M[1:0] == 2'b10) & (|ALUResultM[1:0]));
    if (is_store)
      illegal = ~((funct3M == 3'b000) | (funct3M == 3'b001) | (funct3M == 3'b010));
    else
      illegal = (funct3M == 3'b011) | (funct3M[2:1] == 2'b11);
    // Held low during reset so a stale EX/MEM value cannot raise a trap.
    exc    = rst_n & ValidM & (is_store | is_load) & (misalign | illegal);
    access = ValidM & (is_store | is_load) & ~exc;
  end

  always_comb begin
    fmt_strb  = 4'b1111;
    fmt_wdata = WriteDataM;
    if (is_store) begin
      case (funct3M[1:0])
        2'b00: begin
          fmt_strb  = 4'b0001 << ALUResultM[1:0];
          fmt_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          fmt_strb  = 4'b0011 << {ALUResultM[1], 1'b0};
          fmt_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          fmt_strb  = 4'b1111;
          fmt_wdata = WriteDataM;
        end
      endcase
    end
  end

  always_comb begin
    lane = dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = access;
        if (access) state_d = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_ready) state_d = we_q ? DONE : RSP;
      end
      RSP: begin
        stall = 1'b1;
        if (dmem_rvalid) state_d = DONE;
      end
      DONE: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && access) begin
        addr_q  <= {ALUResultM[31:2], 2'b00};
        wdata_q <= fmt_wdata;
        strb_q  <= fmt_strb;
        we_q    <= is_store;
        f3_q    <= funct3M;
        off_q   <= ALUResultM[1:0];
      end
      // Responses outside RSP (including one coincident with ready) are dropped.
      if (state_q == RSP && dmem_rvalid) rdata_q <= load_ext;
    end
  end

  assign dmem_valid = (state_q == REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_strb  = strb_q;
  assign ReadDataM  = rdata_q;
  assign StallMem   = rst_n & stall;
  assign ExcM       = exc;

endmodule
